// File: rtl/ecc_pkg.sv
// Shared definitions for the 256-bit prime-field arithmetic blocks (ffs, ffa):
// the default field modulus, the default limb width, and the state encoding.
package ecc_pkg;

  localparam int ECC_WIDTH = 256;
  localparam int ECC_LIMB  = 64;

  // secp256k1 field prime
  localparam logic [ECC_WIDTH-1:0] ECC_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // Sequencer states shared by the limb-serial field units
  typedef enum logic [1:0] {
    ECC_IDLE = 2'd0,
    ECC_SUB  = 2'd1,
    ECC_ADDP = 2'd2,
    ECC_DONE = 2'd3
  } ecc_state_e;

  // Number of limbs a full-width operand splits into
  function automatic int ecc_num_limbs(input int limb);
    return ECC_WIDTH / limb;
  endfunction

endpackage

// File: rtl/ffs_if.sv
// Request/response bundle of the field subtractor: start + operands in,
// registered result + one-cycle done pulse out.
interface ffs_if;
  import ecc_pkg::*;

  logic                 start;
  logic [ECC_WIDTH-1:0] a;
  logic [ECC_WIDTH-1:0] b;
  logic [ECC_WIDTH-1:0] out;
  logic                 done;

  modport master (output start, output a, output b, input out, input done);
  modport slave  (input start, input a, input b, output out, output done);

endinterface

// File: rtl/ffs_limb_addsub.sv
// One-limb combinational adder/subtractor.
//   sub=1 : r = x - y - cin, cout = borrow out
//   sub=0 : r = x + y + cin, cout = carry out
module ffs_limb_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] r,
  output logic         cout
);

  logic [W:0] ext;

  // One extra bit catches the carry, or the sign of a negative difference (= borrow)
  always_comb begin
    if (sub) begin
      ext = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
    end else begin
      ext = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    end
  end

  assign r    = ext[W-1:0];
  assign cout = ext[W];

endmodule

// File: rtl/ffs.sv
// Limb-serial modular subtractor: out = (a - b) mod P.
// Pass 1 (SUB) computes a - b limb by limb, LSB first. If that pass ends with a
// borrow, pass 2 (ADDP) adds P back, discarding the final carry.
// Optional build macro FFS_CONST_TIME_EN: pass 2 always runs (adding P or 0),
// so latency is a fixed 2*NL cycles independent of the operands.
module ffs
  import ecc_pkg::*;
#(
  parameter int              LIMB = ECC_LIMB,
  parameter logic [255:0]    P    = ECC_P
) (
  input  logic  clk,
  input  logic  rst,
  ffs_if.slave  bus
);

  localparam int NL   = ecc_num_limbs(LIMB);
  localparam int IDXW = (NL > 1) ? $clog2(NL) : 1;

  localparam logic [1:0] S_IDLE = 2'(ECC_IDLE);
  localparam logic [1:0] S_SUB  = 2'(ECC_SUB);
  localparam logic [1:0] S_ADDP = 2'(ECC_ADDP);
  localparam logic [1:0] S_DONE = 2'(ECC_DONE);

  logic [1:0]      state_reg;
  logic [255:0]    a_sh_reg;   // minuend, consumed from the bottom limb
  logic [255:0]    b_sh_reg;   // subtrahend, consumed from the bottom limb
  logic [255:0]    p_sh_reg;   // correction addend (P or 0), consumed likewise
  logic [255:0]    acc_reg;    // result limbs enter at the top and rotate down
  logic            cy_reg;     // borrow in SUB, carry in ADDP
  logic [IDXW-1:0] idx_reg;
  logic [255:0]    out_reg;
  logic            done_reg;

  logic            op_sub;
  logic [LIMB-1:0] op_x;
  logic [LIMB-1:0] op_y;
  logic [LIMB-1:0] limb_r;
  logic            limb_cout;
  logic            last_limb;
  logic            go_addp;
  logic [255:0]    acc_shift;

  // Drop the bottom limb of v and insert top as the new most-significant limb
  function automatic logic [255:0] shr_in(input logic [255:0] v, input logic [LIMB-1:0] top);
    logic [255+LIMB:0] t;
    t = {top, v};
    return t[255+LIMB:LIMB];
  endfunction

  // The single limb unit is shared: operands come from a/b in SUB, from acc/P in ADDP
  assign op_sub = (state_reg != S_ADDP);
  assign op_x   = op_sub ? a_sh_reg[LIMB-1:0] : acc_reg[LIMB-1:0];
  assign op_y   = op_sub ? b_sh_reg[LIMB-1:0] : p_sh_reg[LIMB-1:0];

  ffs_limb_addsub #(.W(LIMB)) u_limb (
    .x    (op_x),
    .y    (op_y),
    .cin  (cy_reg),
    .sub  (op_sub),
    .r    (limb_r),
    .cout (limb_cout)
  );

  assign last_limb = (idx_reg == IDXW'(NL - 1));
  assign acc_shift = shr_in(acc_reg, limb_r);

`ifdef FFS_CONST_TIME_EN
  assign go_addp = 1'b1;
`else
  assign go_addp = limb_cout;
`endif

  // Sequencer and datapath registers; out/done only move at a completion edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      p_sh_reg  <= '0;
      acc_reg   <= '0;
      cy_reg    <= 1'b0;
      idx_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            cy_reg    <= 1'b0;
            idx_reg   <= '0;
            state_reg <= S_SUB;
          end
        end

        S_SUB: begin
          a_sh_reg <= shr_in(a_sh_reg, '0);
          b_sh_reg <= shr_in(b_sh_reg, '0);
          acc_reg  <= acc_shift;
          cy_reg   <= limb_cout;
          idx_reg  <= idx_reg + IDXW'(1);
          if (last_limb) begin
            idx_reg <= '0;
            if (go_addp) begin
              // A final borrow means the difference wrapped: add P back
              cy_reg    <= 1'b0;
              p_sh_reg  <= limb_cout ? P : '0;
              state_reg <= S_ADDP;
            end else begin
              out_reg   <= acc_shift;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end

        S_ADDP: begin
          acc_reg  <= acc_shift;
          p_sh_reg <= shr_in(p_sh_reg, '0);
          cy_reg   <= limb_cout;
          idx_reg  <= idx_reg + IDXW'(1);
          if (last_limb) begin
            idx_reg   <= '0;
            out_reg   <= acc_shift;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out  = out_reg;
  assign bus.done = done_reg;

endmodule

// File: doc/ffs.md
FFS -- requirements
Module: ffs

Interface
REQ-001 Parameter LIMB, default 64, limb width in bits; SHALL divide 256 (NL = 256/LIMB limbs).
REQ-002 Parameter P, default 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field modulus.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  256  minuend, legal range [0, P-1].
REQ-007 b  input  256  subtrahend, legal range [0, P-1].
REQ-008 out  output  256  registered result (a - b) mod P.
REQ-009 done  output  1  registered one-cycle completion pulse.

Function
REQ-010 States: IDLE, SUB, ADDP, DONE.
REQ-011 IDLE with start=1 at edge E0: latch a, b into internal registers; clear borrow; limb index = 0; go to SUB.
REQ-012 IDLE with start=0: hold state; out and done unchanged, done=0.
REQ-013 SUB: one limb per edge, LSB limb first; diff limb = a_i - b_i - borrow; borrow-out feeds the next limb.
REQ-014 SUB at the edge processing limb NL-1 (E4 for LIMB=64), borrow-out=0: load out with the difference; done=1; go to DONE.
REQ-015 SUB at the last limb, borrow-out=1: go to ADDP; clear carry; limb index = 0.
REQ-016 ADDP: one limb per edge; acc_i + P_i + carry; final carry discarded (mod 2^256).
REQ-017 ADDP last limb (E8 for LIMB=64): load out; done=1; go to DONE.
REQ-018 Latency from E0 to done visible: NL edges without borrow, 2*NL edges with borrow (4 or 8 for LIMB=64).
REQ-019 DONE lasts exactly one cycle: done=1; next edge sets done=0 and returns to IDLE.
REQ-020 start in SUB, ADDP or DONE is ignored; no queuing.
REQ-021 out changes only at a completion edge and holds between operations.
REQ-022 a and b may change after E0 without affecting the result.
REQ-023 Out-of-range inputs (>= P): result = the same two-pass computation mod 2^256; no error flag.

Reset
REQ-024 rst=0 at an edge, in any state, including mid-SUB or mid-ADDP: state=IDLE, out=0, done=0, borrow/carry=0, limb index=0.
REQ-025 Reset aborts an in-flight operation; no partial result reaches out.

Configuration
REQ-026 Macro FFS_CONST_TIME_EN defined: ADDP always runs; adds P when SUB borrow=1, else adds 0; latency fixed at 2*NL (8).
REQ-027 Macro undefined: ADDP is skipped when borrow=0, per REQ-014/REQ-015.
REQ-028 Result values are identical in both builds.

Structure
REQ-029 Shared package ecc_pkg: default modulus constant, default limb width, and the state enum type shared with ffa.
REQ-030 One sub-module, ffs_limb_addsub: combinational LIMB-bit add/subtract with carry/borrow in and out, and a mode select; instantiated once and shared by SUB and ADDP.

Verification
REQ-031 a=15, b=10, start pulse -> out=5, done after 4 cycles (8 with FFS_CONST_TIME_EN).
REQ-032 a=10, b=15 -> out=P-5=...FFFFFFFE_FFFFFC2A, done after 8 cycles.
REQ-033 a=b=0x1234 -> out=0, done after 4 cycles; a=0, b=P-1 -> out=1, done after 8 cycles.
REQ-034 rst=0 during the 2nd SUB cycle -> out=0, done=0, IDLE; then a=7, b=3 -> out=4.
REQ-035 Extra start pulses during SUB and ADDP -> ignored; exactly one done pulse, 1 cycle wide; out held afterwards.
REQ-036 1000 random pairs in [0, P-1] checked against a reference model; the FFS_CONST_TIME_EN build checked for constant 8-cycle latency.
